// File: rtl/fec_adc_packer_if.sv
// Snapshot-in / word-stream-out handshake bundle for fec_adc_packer.
// The slave side is the packer; the master side is the surrounding monitor/readout.
interface fec_adc_packer_if;
  logic [149:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_first;
  logic         out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_first, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_first, out_last
  );
endinterface

// File: rtl/fec_adc_packer.sv
// Captures a 3-chip AD7417 snapshot, flags over-temperature per chip and
// streams it out as one header word plus fifteen channel words.
module fec_adc_packer #(
  parameter logic signed [9:0] TEMP_LIMIT = 10'sd340,
  parameter logic [7:0]        HEADER_TAG = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  fec_adc_packer_if.slave   bus,
  output logic [2:0]        over_temp,
  output logic              alarm_sticky,
  input  logic              alarm_clr,
  output logic [7:0]        seq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  localparam logic [4:0] LAST_K = 5'd14;

  state_t       state;
  logic [4:0]   k;
  logic [149:0] cap;
  logic [2:0]   over_temp_new;
  logic         capture;
  logic [7:0]   seq_next;

  // Temperature channels sit at k = 0, 5, 10 (bit offsets 0, 50, 100).
  always_comb begin
    over_temp_new = '0;
    for (int c = 0; c < 3; c++) begin
      over_temp_new[c] = $signed(bus.in_data[c*50 +: 10]) > TEMP_LIMIT;
    end
  end

  assign capture  = (state == IDLE) && bus.in_valid && bus.in_ready;
  assign seq_next = seq + 8'd1;

  // Channel word: {index, alarm flag (temperature channels only), raw value}.
  function automatic logic [15:0] data_word(input logic [149:0] snap,
                                            input logic [2:0]   ot,
                                            input logic [4:0]   idx);
    int unsigned i;
    logic        alarm;
    i     = 32'(idx);
    alarm = ((i % 5) == 0) ? ot[i / 5] : 1'b0;
    return {idx, alarm, snap[i*10 +: 10]};
  endfunction

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      k             <= '0;
      // NOTE: the capture register is a plain flop bank, not a RAM, so it is
      // cleared with everything else and never leaks a stale snapshot.
      cap           <= '0;
      over_temp     <= '0;
      alarm_sticky  <= 1'b0;
      seq           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      // A set at capture wins over a coincident clear.
      if (capture && |over_temp_new) begin
        alarm_sticky <= 1'b1;
      end else if (alarm_clr) begin
        alarm_sticky <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (capture) begin
            cap           <= bus.in_data;
            over_temp     <= over_temp_new;
            seq           <= seq_next;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_first <= 1'b1;
            bus.out_last  <= 1'b0;
            bus.out_data  <= {HEADER_TAG, seq_next};
            state         <= HEADER;
          end
        end

        HEADER: begin
          if (bus.out_ready) begin
            k             <= '0;
            bus.out_first <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= data_word(cap, over_temp, 5'd0);
            state         <= DATA;
          end
        end

        DATA: begin
          if (bus.out_ready) begin
            if (k == LAST_K) begin
              k             <= '0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.out_data  <= '0;
              bus.in_ready  <= 1'b1;
              state         <= IDLE;
            end else begin
              k             <= k + 5'd1;
              bus.out_last  <= (k + 5'd1) == LAST_K;
              bus.out_data  <= data_word(cap, over_temp, k + 5'd1);
            end
          end
        end

        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.out_first <= 1'b0;
          bus.out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fec_adc_packer.sv
// Scoreboard bench for fec_adc_packer: directed snapshots push expected words,
// an independent monitor pops and compares each accepted output word.
module tb_fec_adc_packer;

  typedef struct packed {
    logic        first;
    logic        last;
    logic [15:0] data;
  } word_t;

  logic       clk;
  logic       rst_n;
  logic       alarm_clr;
  logic [2:0] over_temp;
  logic       alarm_sticky;
  logic [7:0] seq;

  fec_adc_packer_if bus ();

  fec_adc_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .over_temp    (over_temp),
    .alarm_sticky (alarm_sticky),
    .alarm_clr    (alarm_clr),
    .seq          (seq)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t exp_q[$];
  logic [7:0] exp_seq = 8'd0;
  bit    rand_rdy = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Downstream ready: held high, or ~50% random when rand_rdy is set.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares each transferred word and checks words stay put under stall.
  initial begin
    word_t held;
    bit    held_v;
    word_t act;
    word_t exp;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      act = '{first: bus.out_first, last: bus.out_last, data: bus.out_data};
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v && bus.out_valid) check("stall_hold", 32'(act), 32'(held));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            timeout("unexpected_word");
          end else begin
            exp = exp_q.pop_front();
            check(exp.first ? "header_word" : "data_word", 32'(act), 32'(exp));
          end
          held_v = 1'b0;
        end else if (bus.out_valid) begin
          held   = act;
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  function automatic logic [149:0] mk_data(input int base);
    logic [149:0] d;
    for (int k = 0; k < 15; k++) begin
      d[10*k +: 10] = (k % 5 == 0) ? 10'((base + k) % 256) : 10'((base + k * 13) % 1024);
    end
    return d;
  endfunction

  // Queue the expected record then present the snapshot until accepted.
  task automatic send_snap(input logic [149:0] d, input logic [2:0] ot, input bit clr_same);
    bit ok;
    exp_seq = exp_seq + 8'd1;
    exp_q.push_back('{first: 1'b1, last: 1'b0, data: {8'hA5, exp_seq}});
    for (int k = 0; k < 15; k++) begin
      exp_q.push_back('{first: 1'b0, last: (k == 14),
                        data: {5'(k), (k % 5 == 0) ? ot[k/5] : 1'b0, d[10*k +: 10]}});
    end
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    alarm_clr    = clr_same;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) timeout("accept");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    alarm_clr    = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && bus.in_ready;
    end
    if (!ok) timeout("stream_done");
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [149:0] d;
    int           cnt;
    bit           ok;

    rst_n        = 1'b0;
    alarm_clr    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_first", 32'(bus.out_first), 32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_over_temp", 32'(over_temp),     32'd0);
    check("rst_sticky",    32'(alarm_sticky),  32'd0);
    check("rst_seq",       32'(seq),           32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp snapshot k*10; in_ready must stay low for exactly 16 cycles.
    for (int k = 0; k < 15; k++) d[10*k +: 10] = 10'(k * 10);
    send_snap(d, 3'b000, 1'b0);
    cnt = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else cnt++;
    end
    check("in_ready_low_cycles", 32'(cnt), 32'd16);
    check("seq_after_first", 32'(seq), 32'd1);
    wait_done();

    // Limit boundary: 341 alarms, 340 does not, -0.25 degC does not.
    for (int k = 0; k < 15; k++) d[10*k +: 10] = 10'(k * 37 + 3);
    d[9:0]     = 10'd341;
    d[59:50]   = 10'd340;
    d[109:100] = 10'h3FF;
    send_snap(d, 3'b001, 1'b0);
    check("ot_boundary", 32'(over_temp), 32'd1);
    check("sticky_set", 32'(alarm_sticky), 32'd1);
    wait_done();
    check("ot_holds_idle", 32'(over_temp), 32'd1);

    // Clear in idle, then a clear coinciding with an alarming capture.
    alarm_clr = 1'b1;
    @(posedge clk);
    #1;
    alarm_clr = 1'b0;
    check("sticky_cleared", 32'(alarm_sticky), 32'd0);
    d[9:0]     = 10'd0;
    d[59:50]   = 10'd511;
    d[109:100] = 10'd400;
    send_snap(d, 3'b110, 1'b1);
    check("sticky_set_beats_clr", 32'(alarm_sticky), 32'd1);
    check("ot_two_chips", 32'(over_temp), 32'd6);
    wait_done();
    alarm_clr = 1'b1;
    @(posedge clk);
    #1;
    alarm_clr = 1'b0;
    check("sticky_clr_later", 32'(alarm_sticky), 32'd0);

    // Three back-to-back snapshots under random backpressure.
    rand_rdy = 1'b1;
    send_snap(mk_data(11), 3'b000, 1'b0);
    send_snap(mk_data(22), 3'b000, 1'b0);
    send_snap(mk_data(33), 3'b000, 1'b0);
    wait_done();
    rand_rdy = 1'b0;
    check("seq_after_bp", 32'(seq), 32'(exp_seq));

    // Run seq round to wrap; the last header carries 8'h00.
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      send_snap(mk_data(i), 3'b000, 1'b0);
      ok = (exp_seq == 8'd0);
    end
    wait_done();
    check("seq_wrapped", 32'(seq), 32'd0);

    // Asynchronous reset mid-stream at k=7.
    send_snap(mk_data(77), 3'b000, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.out_valid && !bus.out_first && (bus.out_data[15:11] == 5'd7);
    end
    if (!ok) timeout("reach_k7");
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    check("arst_seq",       32'(seq),           32'd0);
    check("arst_out_last",  32'(bus.out_last),  32'd0);
    exp_q.delete();
    exp_seq = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(bus.out_valid), 32'd0);
    send_snap(mk_data(5), 3'b000, 1'b0);
    wait_done();
    check("post_rst_seq", 32'(seq), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fec_adc_packer.md
Name: fec_adc_packer

Overview:
Downstream stage of the FEC AD7417 monitor. It accepts one 150-bit snapshot (3 chips x 5 channels x 10 bits) over a valid/ready handshake and checks each chip's temperature against a limit. It then emits the snapshot as a 16-word, 16-bit stream (one header plus 15 channel words) for the slow-control readout path.

Parameters:
TEMP_LIMIT, 10'sd340, signed over-temperature threshold in AD7417 LSBs (0.25 degC/LSB; 340 = 85 degC); alarm when temp > TEMP_LIMIT
HEADER_TAG, 8'hA5, constant placed in header word bits [15:8]

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_data  in  150  snapshot; channel k = in_data[10k+9:10k], k = chip*5+ch; chip 0/1/2 = IC13/IC14/IC15; ch 0 = temp, 1..4 = AN1..AN4
in_valid  in  1  snapshot valid
in_ready  out  1  block can accept a snapshot
out_data  out  16  stream word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts word
out_first  out  1  high with the header word
out_last  out  1  high with word for k=14
over_temp  out  3  per-chip alarm from the most recently accepted snapshot
alarm_sticky  out  1  set when any over_temp bit is set at capture; held until cleared
alarm_clr  in  1  single-cycle clear of alarm_sticky
seq  out  8  count of accepted snapshots, mod 256

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_first=0, out_last=0, out_data=0, over_temp=0, alarm_sticky=0, seq=0, word counter=0, capture register=0.
- Reset asserted mid-stream aborts the stream immediately. No partial words are emitted after reset releases.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data, update over_temp, increment seq, go to HEADER.
  - HEADER: out_valid=1, out_first=1, out_data={HEADER_TAG, seq after increment}. On out_ready, go to DATA with k=0.
  - DATA: out_valid=1, out_data={k[4:0], alarm_bit, value[9:0]}.
    - alarm_bit = over_temp[chip] for ch=0; 0 for analog channels.
    - out_last=1 when k=14.
    - On out_ready: if k<14, k increments; if k=14, go to IDLE.
- Latency: header is presented on the cycle after input acceptance. A full record takes a minimum of 16 cycles with out_ready held high. in_ready returns high the cycle after the last word is accepted.
- in_ready is 0 in HEADER and DATA. Upstream holds its snapshot; no snapshot is ever dropped or overwritten mid-stream.
- out_data, out_first and out_last are stable while out_valid=1 and out_ready=0. Backpressure of any length is tolerated.
- Temperature compare:
  - Value is 10-bit two's complement, compared signed; alarm when value > TEMP_LIMIT (equal is not an alarm).
  - Negative temperatures, e.g. 10'h3FF = -0.25 degC, never alarm.
  - Analog channels are passed through unsigned and unchecked.
- seq wraps from 255 to 0.
- alarm_sticky:
  - Set on capture if |over_temp_new.
  - Cleared by alarm_clr when no set is occurring.
  - A simultaneous set and clear leaves it set.
- over_temp holds between snapshots. It updates only at capture.

Test Plan:
- Reset then one snapshot, all channels k=value 10'd(k*10), out_ready=1 -> header 16'hA501 with out_first; words 0..14 = {k,0,k*10}; out_last only on k=14; in_ready low for 16 cycles.
- Temps IC13=341, IC14=340, IC15=10'h3FF -> over_temp=3'b001, word0 bit10=1, words 5 and 10 bit10=0, alarm_sticky=1.
- Random out_ready toggling (~50%) over 3 back-to-back snapshots -> identical word sequences, no duplicates or losses, output held stable while stalled, seq=1,2,3.
- alarm_clr asserted in the same cycle as a capture that raises an alarm -> alarm_sticky stays 1. alarm_clr in a later cycle with no alarm -> 0.
- 256 snapshots accepted -> header of the 256th shows seq 8'h00.
- rst_n pulsed low during DATA at k=7 -> out_valid=0 asynchronously, seq=0, in_ready=1; next snapshot streams from the header.
